pwm_ramp_ctrl: RTL and testbench
================================

// Module: pwm_ramp_ctrl
// PURPOSE
// - Motor-drive sequencer placed in front of the pwm generator; one instance per motor channel.
// - Accepts speed/direction commands and slews o_duty toward the target at a fixed rate (soft start/stop).
// - Forces a ramp to zero plus a dead interval before any direction reversal.
// - Provides an emergency-stop override.
// PARAMETERS
// - CLK_FREQ       100000000                     clk frequency, Hz
// - PWM_FREQ       20000                         PWM frequency, Hz; PWM_MAX = CLK_FREQ/PWM_FREQ
// - WL             $clog2(CLK_FREQ/PWM_FREQ)     duty word width; matches the pwm i_duty_cycle width
// - RAMP_TICK_CYC  100000                        clk cycles per ramp tick (1 ms at default)
// - STEP           8                             duty change per ramp tick, >=1
// - DEAD_TICKS     5                             ramp ticks held at zero duty before a direction flip
// - WDOG_TICKS     250                           ramp ticks without a command before watchdog trip
// PORTS
// - clk          in   1    clock
// - reset        in   1    synchronous, active-high reset
// - i_cmd_valid  in   1    command valid
// - o_cmd_ready  out  1    command ready; transfer occurs when i_cmd_valid & o_cmd_ready
// - i_cmd_duty   in   WL   target duty; values > PWM_MAX are clamped to PWM_MAX on accept
// - i_cmd_dir    in   1    target direction (0 fwd, 1 rev)
// - i_estop      in   1    emergency stop, level-sensitive
// - o_duty       out  WL   duty to the pwm block
// - o_dir        out  1    direction to the H-bridge
// - o_at_target  out  1    high when state==IDLE (o_duty==target, o_dir==target dir)
// - o_wdog_trip  out  1    watchdog tripped (sticky until the next accepted command)
// BEHAVIOUR
// - Interface: reset and clock are decided as "reset reset, synchronous, active-high; clock clk".
// - Reset: state IDLE; o_duty=0; o_dir=0; target duty/dir=0; tick counter=0; o_cmd_ready=1; o_at_target=1; o_wdog_trip=0.
// - Tick generator:
//   - Free-running counter 0..RAMP_TICK_CYC-1; tick is a 1-cycle pulse at wrap.
//   - The counter is reset only by reset.
// - Command acceptance:
//   - On accept, latch the clamped duty and the dir; take effect the next cycle.
//   - A new command overrides the current target mid-ramp, without restarting the tick counter.
//   - o_cmd_ready = !i_estop; commands are also accepted in DEAD, with the flip decision re-evaluated at DEAD exit.
// - FSM IDLE:
//   - Go to RAMP the cycle after target != (o_duty, o_dir).
// - FSM RAMP, on each tick:
//   - If tgt_dir==o_dir: o_duty moves toward tgt_duty by STEP, landing exactly on the target with no overshoot or underflow. When equal -> IDLE.
//   - If tgt_dir!=o_dir: o_duty decreases by min(STEP, o_duty). At 0 -> DEAD.
// - FSM DEAD:
//   - o_duty held at 0; count DEAD_TICKS ticks.
//   - At the last tick: if tgt_dir!=o_dir, toggle o_dir. Then -> RAMP, or -> IDLE if tgt_duty==0.
// - Arithmetic: internal compare/subtract uses WL+1 bits so no wrap is possible; PWM_MAX is cast to WL bits.
// - E-stop (highest priority, any state):
//   - Next cycle: o_duty=0, target duty=0, target dir=o_dir, state IDLE, dead counter cleared.
//   - o_dir is unchanged.
//   - After i_estop deasserts, normal operation resumes with ready=1.
// - Reset mid-ramp returns all outputs to reset values on the next edge.
// CONFIGURATION
// - Macro PWM_RAMP_WDOG_EN:
//   - Defined: a counter of ticks since the last accepted command. On reaching WDOG_TICKS it sets o_wdog_trip and sets target duty=0 (graceful ramp down, dir kept). Any accepted command clears the trip and the counter.
//   - Undefined: the watchdog logic is absent and o_wdog_trip is tied 0.
// TESTING (bench params: CLK_FREQ=1000, PWM_FREQ=10 -> PWM_MAX=100, WL=7, RAMP_TICK_CYC=4, STEP=8, DEAD_TICKS=2, WDOG_TICKS=20)
// - Reset, cmd(duty=40, dir=0) -> o_duty 8,16,24,32,40 on successive ticks; o_at_target=1 after the 5th tick.
// - From duty 40, cmd(duty=90) -> 48..88, then 90 (final partial step); cmd(duty=127) -> clamped, settles at 100.
// - From duty 20 fwd, cmd(duty=16, dir=1) -> 12,4,0; 2 ticks at 0; o_dir=1; then 8,16; o_duty never rises while o_dir=0.
// - Mid-ramp (o_duty=24 rising to 80), assert i_estop -> o_duty=0 next cycle, o_cmd_ready=0 while asserted, IDLE after release.
// - Reversal in DEAD, then cmd(dir=0, duty=30) before DEAD ends -> no flip, o_dir stays 0, ramps to 30.
// - PWM_RAMP_WDOG_EN, hold at 40 with no cmd -> trip after 20 ticks, ramp to 0; new cmd clears trip. Without the macro, o_wdog_trip stays 0.

Source files
------------

// File: rtl/pwm_ramp_ctrl.sv
// rtl/pwm_ramp_ctrl.sv - duty slew sequencer with reversal dead time and e-stop override
// Optional command watchdog enabled by defining PWM_RAMP_WDOG_EN.
module pwm_ramp_ctrl #(
   parameter int CLK_FREQ      = 100000000,
   parameter int PWM_FREQ      = 20000,
   parameter int WL            = $clog2(CLK_FREQ / PWM_FREQ),
   parameter int RAMP_TICK_CYC = 100000,
   parameter int STEP          = 8,
   parameter int DEAD_TICKS    = 5,
   parameter int WDOG_TICKS    = 250
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          i_cmd_valid,
   output logic          o_cmd_ready,
   input  logic [WL-1:0] i_cmd_duty,
   input  logic          i_cmd_dir,
   input  logic          i_estop,
   output logic [WL-1:0] o_duty,
   output logic          o_dir,
   output logic          o_at_target,
   output logic          o_wdog_trip
);

   localparam int PWM_MAX = CLK_FREQ / PWM_FREQ;
   localparam int WL1     = WL + 1;
   localparam int TCW     = (RAMP_TICK_CYC > 1) ? $clog2(RAMP_TICK_CYC) : 1;
   localparam int DCW     = (DEAD_TICKS > 1) ? $clog2(DEAD_TICKS) : 1;

   localparam logic [WL-1:0]  MAX_DUTY  = WL'(PWM_MAX);
   localparam logic [WL:0]    STEP_X    = WL1'(STEP);
   localparam logic [TCW-1:0] TICK_LAST = TCW'(RAMP_TICK_CYC - 1);
   localparam logic [DCW-1:0] DEAD_LAST = DCW'(DEAD_TICKS - 1);

   typedef enum logic [1:0] {IDLE, RAMP, DEAD} state_t;

   state_t         state, state_n;
   logic [TCW-1:0] tick_cnt;
   logic           tick;
   logic [DCW-1:0] dead_cnt, dead_cnt_n;
   logic [WL-1:0]  tgt_duty, duty_n, cmd_duty_clamped;
   logic           tgt_dir, dir_n;
   logic           cmd_fire, wdog_fire;
   logic [WL:0]    duty_x, tgt_x, up_x, toward_x, down_x;

   // Tick generator runs freely; commands never restart it.
   always_ff @(posedge clk) begin
      if (reset || tick)
         tick_cnt <= '0;
      else
         tick_cnt <= tick_cnt + TCW'(1);
   end
   assign tick = (tick_cnt == TICK_LAST);

   assign o_cmd_ready      = !i_estop;
   assign cmd_fire         = i_cmd_valid && o_cmd_ready;
   assign cmd_duty_clamped = ({1'b0, i_cmd_duty} > {1'b0, MAX_DUTY}) ? MAX_DUTY : i_cmd_duty;

   always_ff @(posedge clk) begin
      if (reset) begin
         tgt_duty <= '0;
         tgt_dir  <= 1'b0;
      end else if (i_estop) begin
         tgt_duty <= '0;
         tgt_dir  <= o_dir;
      end else if (cmd_fire) begin
         tgt_duty <= cmd_duty_clamped;
         tgt_dir  <= i_cmd_dir;
      end else if (wdog_fire) begin
         tgt_duty <= '0;
      end
   end

   // One extra bit keeps the step arithmetic from wrapping at either end.
   assign duty_x = {1'b0, o_duty};
   assign tgt_x  = {1'b0, tgt_duty};
   assign up_x   = duty_x + STEP_X;
   assign down_x = (duty_x > STEP_X) ? (duty_x - STEP_X) : '0;

   always_comb begin
      toward_x = tgt_x;
      if (duty_x < tgt_x) begin
         if (up_x < tgt_x)
            toward_x = up_x;
      end else if ((duty_x - tgt_x) > STEP_X) begin
         toward_x = duty_x - STEP_X;
      end
   end

   always_comb begin
      state_n    = state;
      duty_n     = o_duty;
      dir_n      = o_dir;
      dead_cnt_n = dead_cnt;
      case (state)
         IDLE: begin
            if (tgt_duty != o_duty || tgt_dir != o_dir)
               state_n = RAMP;
         end
         RAMP: begin
            if (tick) begin
               if (tgt_dir == o_dir) begin
                  duty_n = toward_x[WL-1:0];
                  if (toward_x == tgt_x)
                     state_n = IDLE;
               end else begin
                  duty_n = down_x[WL-1:0];
                  if (down_x == '0) begin
                     state_n    = DEAD;
                     dead_cnt_n = '0;
                  end
               end
            end
         end
         DEAD: begin
            duty_n = '0;
            if (tick) begin
               if (dead_cnt == DEAD_LAST) begin
                  dead_cnt_n = '0;
                  if (tgt_dir != o_dir)
                     dir_n = ~o_dir;
                  state_n = (tgt_duty == '0) ? IDLE : RAMP;
               end else begin
                  dead_cnt_n = dead_cnt + DCW'(1);
               end
            end
         end
         default: state_n = IDLE;
      endcase
      if (i_estop) begin
         state_n    = IDLE;
         duty_n     = '0;
         dir_n      = o_dir;
         dead_cnt_n = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         o_duty   <= '0;
         o_dir    <= 1'b0;
         dead_cnt <= '0;
      end else begin
         state    <= state_n;
         o_duty   <= duty_n;
         o_dir    <= dir_n;
         dead_cnt <= dead_cnt_n;
      end
   end

   assign o_at_target = (state == IDLE);

`ifdef PWM_RAMP_WDOG_EN
   localparam int WDW = $clog2(WDOG_TICKS + 1);
   localparam logic [WDW-1:0] WDOG_LAST = WDW'(WDOG_TICKS - 1);
   localparam logic [WDW-1:0] WDOG_SAT  = WDW'(WDOG_TICKS);

   logic [WDW-1:0] wdog_cnt;
   logic           wdog_trip;

   // Counter saturates at the trip point so the target is zeroed only once.
   assign wdog_fire = tick && !cmd_fire && (wdog_cnt == WDOG_LAST);

   always_ff @(posedge clk) begin
      if (reset || cmd_fire) begin
         wdog_cnt  <= '0;
         wdog_trip <= 1'b0;
      end else if (tick && wdog_cnt != WDOG_SAT) begin
         wdog_cnt <= wdog_cnt + WDW'(1);
         if (wdog_cnt == WDOG_LAST)
            wdog_trip <= 1'b1;
      end
   end
   assign o_wdog_trip = wdog_trip;
`else
   logic unused_wdog;
   assign unused_wdog = (WDOG_TICKS != 0);
   assign wdog_fire   = 1'b0;
   assign o_wdog_trip = 1'b0;
`endif

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// tb/tb_pwm_ramp_ctrl.sv - scoreboard bench for pwm_ramp_ctrl against a cycle-level reference model
`timescale 1ns/1ps
module tb_pwm_ramp_ctrl;
   localparam int CLK_FREQ = 1000;
   localparam int PWM_FREQ = 10;
   localparam int WL       = 7;
   localparam int TICK     = 4;
   localparam int STEP     = 8;
   localparam int DEAD     = 2;
   localparam int WDOG     = 20;
   localparam int PWM_MAX  = CLK_FREQ / PWM_FREQ;
`ifdef PWM_RAMP_WDOG_EN
   localparam bit WDOG_EN = 1'b1;
`else
   localparam bit WDOG_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [WL-1:0] cmd_duty = '0;
   logic          cmd_dir = 1'b0;
   logic          estop = 1'b0;
   logic [WL-1:0] duty;
   logic          dir, at_target, wdog_trip;

   int checks = 0;
   int failures = 0;

   typedef struct {
      int duty;
      bit dir;
      bit at_target;
      bit trip;
   } exp_t;
   exp_t exp_q[$];

   // Reference model state: plain integers describing the motor's commanded motion.
   int m_duty, m_dir, t_duty, t_dir, tpos, dead_left, wd;
   bit settled, trip;

   always #5 clk = ~clk;

   pwm_ramp_ctrl #(
      .CLK_FREQ(CLK_FREQ), .PWM_FREQ(PWM_FREQ), .WL(WL), .RAMP_TICK_CYC(TICK),
      .STEP(STEP), .DEAD_TICKS(DEAD), .WDOG_TICKS(WDOG)
   ) dut (
      .clk(clk), .reset(reset), .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
      .i_cmd_duty(cmd_duty), .i_cmd_dir(cmd_dir), .i_estop(estop),
      .o_duty(duty), .o_dir(dir), .o_at_target(at_target), .o_wdog_trip(wdog_trip)
   );

   task automatic model_step();
      bit   tick, fire;
      int   old_dir, diff, step;
      exp_t e;
      if (reset) begin
         m_duty = 0; m_dir = 0; t_duty = 0; t_dir = 0; tpos = 0;
         dead_left = 0; settled = 1; wd = 0; trip = 0;
      end else begin
         tick    = (tpos == TICK - 1);
         fire    = cmd_valid && !estop;
         tpos    = tick ? 0 : tpos + 1;
         old_dir = m_dir;
         if (estop) begin
            m_duty = 0; settled = 1; dead_left = 0;
         end else if (settled) begin
            settled = (t_duty == m_duty) && (t_dir == m_dir);
         end else if (dead_left > 0) begin
            if (tick) begin
               dead_left--;
               if (dead_left == 0) begin
                  m_dir   = t_dir;
                  settled = (t_duty == 0);
               end
            end
         end else if (tick) begin
            if (t_dir == m_dir) begin
               diff = t_duty - m_duty;
               step = (diff < 0) ? -diff : diff;
               if (step > STEP) step = STEP;
               m_duty  = m_duty + ((diff > 0) ? step : -step);
               settled = (m_duty == t_duty);
            end else begin
               m_duty = m_duty - ((m_duty < STEP) ? m_duty : STEP);
               if (m_duty == 0) dead_left = DEAD;
            end
         end
         if (estop) begin
            t_duty = 0; t_dir = old_dir;
         end else if (fire) begin
            t_duty = (int'(cmd_duty) > PWM_MAX) ? PWM_MAX : int'(cmd_duty);
            t_dir  = cmd_dir;
         end
         if (fire) begin
            wd = 0; trip = 0;
         end else if (WDOG_EN && tick && wd < WDOG) begin
            wd++;
            if (wd == WDOG) begin
               trip   = 1;
               t_duty = 0;
            end
         end
      end
      e.duty = m_duty; e.dir = m_dir[0]; e.at_target = settled; e.trip = trip;
      exp_q.push_back(e);
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (duty !== WL'(e.duty) || dir !== e.dir || at_target !== e.at_target ||
                wdog_trip !== e.trip || cmd_ready !== !estop) begin
               failures++;
               $display("FAIL scoreboard t=%0t: got duty=%0d dir=%b at_target=%b trip=%b ready=%b, expected duty=%0d dir=%b at_target=%b trip=%b ready=%b",
                        $time, duty, dir, at_target, wdog_trip, cmd_ready,
                        e.duty, e.dir, e.at_target, e.trip, !estop);
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input int d, input bit r);
      cmd_valid = 1'b1;
      cmd_duty  = WL'(d);
      cmd_dir   = r;
      cyc(1);
      cmd_valid = 1'b0;
   endtask

   task automatic wait_duty_change(input int budget);
      int prev;
      prev = duty;
      for (int i = 0; i < budget; i++) begin
         cyc(1);
         if (duty != prev) break;
      end
   endtask

   initial begin
      int r;
      cyc(3);
      reset = 1'b0;
      check("reset_duty", duty, 0);
      check("reset_at_target", at_target, 1);
      check("reset_ready", cmd_ready, 1);
      check("reset_trip", wdog_trip, 0);

      send(40, 0);
      for (int k = 1; k <= 5; k++) begin
         wait_duty_change(12);
         check("soft_start", duty, 8 * k);
      end
      check("soft_start_at_target", at_target, 1);

      send(90, 0);
      for (int k = 1; k <= 7; k++) begin
         wait_duty_change(12);
         check("ramp_to_90", duty, (40 + 8 * k > 90) ? 90 : 40 + 8 * k);
      end
      send(127, 0);
      wait_duty_change(12);
      check("clamp_step", duty, 98);
      wait_duty_change(12);
      check("clamp_final", duty, 100);
      cyc(20);
      check("clamp_hold", duty, 100);

      send(20, 0);
      cyc(60);
      check("down_to_20", duty, 20);
      send(16, 1);
      for (int k = 0; k < 3; k++) begin
         wait_duty_change(12);
         check("reverse_down", duty, (k == 0) ? 12 : (k == 1) ? 4 : 0);
      end
      for (int i = 0; i < 16 && dir != 1'b1; i++) cyc(1);
      check("reverse_dir", dir, 1);
      check("reverse_dead_duty", duty, 0);
      wait_duty_change(12);
      check("reverse_up1", duty, 8);
      wait_duty_change(12);
      check("reverse_up2", duty, 16);
      check("reverse_at_target", at_target, 1);

      send(0, 0);
      cyc(60);
      check("back_fwd_dir", dir, 0);
      send(80, 0);
      for (int i = 0; i < 30 && duty != 24; i++) cyc(1);
      check("pre_estop_duty", duty, 24);
      estop = 1'b1;
      cyc(1);
      check("estop_duty", duty, 0);
      check("estop_ready", cmd_ready, 0);
      cyc(5);
      check("estop_hold", duty, 0);
      estop = 1'b0;
      cyc(2);
      check("estop_release_idle", at_target, 1);
      check("estop_release_ready", cmd_ready, 1);

      send(20, 0);
      cyc(40);
      check("dead_pre", duty, 20);
      send(30, 1);
      for (int i = 0; i < 30 && duty != 0; i++) cyc(1);
      send(30, 0);
      cyc(60);
      check("dead_override_dir", dir, 0);
      check("dead_override_duty", duty, 30);

`ifdef PWM_RAMP_WDOG_EN
      send(40, 0);
      cyc(100);
      check("wdog_trip", wdog_trip, 1);
      cyc(40);
      check("wdog_ramp_zero", duty, 0);
      send(10, 0);
      check("wdog_clear", wdog_trip, 0);
`else
      cyc(150);
      check("wdog_absent", wdog_trip, 0);
`endif

      for (int n = 0; n < 300; n++) begin
         r = $urandom_range(0, 99);
         if (r < 60) begin
            send($urandom_range(0, 127), 1'($urandom_range(0, 1)));
            cyc($urandom_range(0, 30));
         end else if (r < 72) begin
            estop = 1'b1;
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_duty  = WL'($urandom_range(0, 127));
            cmd_dir   = 1'($urandom_range(0, 1));
            cyc($urandom_range(1, 6));
            estop = 1'b0;
            cmd_valid = 1'b0;
         end else if (r < 75) begin
            reset = 1'b1;
            cyc(1);
            reset = 1'b0;
         end else begin
            cyc($urandom_range(20, 60));
         end
      end

      cyc(5);
      @(negedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
